// File: rtl/sram16_pkg.sv
// Shared types and constants for the 16-bit async SRAM bus sequencer.
// Strobe vectors are ordered {ce_n, oe_n, we_n, lb_n, ub_n}.
package sram16_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWPulse,
        StWHold,
        StRAccess,
        StRTurn
    } state_e;

    localparam int unsigned DefAddrW      = 18;
    localparam int unsigned DefWaitCycles = 1;
    localparam int unsigned DefTurnCycles = 1;

    localparam logic [4:0] IdleStrobes = 5'b11111;

endpackage

// File: rtl/sram16_bus_ctrl.sv
// Bus-side sequencer turning single-word req/rsp transactions into timed SRAM strobes,
// with a guaranteed turnaround after reads so the FPGA and the SRAM never both drive the bus.
module sram16_bus_ctrl
    import sram16_pkg::*;
#(
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles,
    parameter int unsigned TURN_CYCLES = DefTurnCycles
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    input  logic [1:0]        req_be,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic [15:0]       io_write,
    output logic              io_write_enable,
    input  logic [15:0]       io_read,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_lb_n,
    output logic              sram_ub_n
);

    if (TURN_CYCLES == 0) begin : g_bad_turn
        $error("TURN_CYCLES must be at least 1");
    end

    localparam int unsigned MaxCycles = (WAIT_CYCLES > TURN_CYCLES) ? WAIT_CYCLES : TURN_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] WaitLoad = CntW'(WAIT_CYCLES);
    localparam logic [CntW-1:0] TurnLoad = CntW'(TURN_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      be_q, be_d;
    logic            accept;
    logic [4:0]      strb_d;
    logic            wen_d;
    logic            rsp_valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = (state_q == StIdle) && req_valid;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = req_write ? StWSetup : StRAccess;
                    cnt_d   = req_write ? '0 : WaitLoad;
                end
            end
            StWSetup: begin
                state_d = StWPulse;
                cnt_d   = WaitLoad;
            end
            StWPulse: begin
                if (cnt_q == '0) begin
                    state_d = StWHold;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StWHold: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            StRAccess: begin
                if (cnt_q == '0) begin
                    state_d = StRTurn;
                    cnt_d   = TurnLoad;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StRTurn: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered, so decode them from the state being entered.
    always_comb begin
        be_d        = accept ? req_be : be_q;
        strb_d      = IdleStrobes;
        wen_d       = 1'b0;
        rsp_valid_d = (state_q == StRAccess) && (cnt_q == '0);

        unique case (state_d)
            StWSetup, StWHold: begin
                strb_d = {1'b0, 1'b1, 1'b1, ~be_d[0], ~be_d[1]};
                wen_d  = 1'b1;
            end
            StWPulse: begin
                // An all-zero byte mask still walks the sequence but never pulses WE.
                strb_d = {1'b0, 1'b1, (be_d == 2'b00), ~be_d[0], ~be_d[1]};
                wen_d  = 1'b1;
            end
            StRAccess: begin
                strb_d = 5'b00100;
            end
            default: begin
                strb_d = IdleStrobes;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            be_q            <= '0;
            sram_addr       <= '0;
            io_write        <= '0;
            io_write_enable <= 1'b0;
            sram_ce_n       <= 1'b1;
            sram_oe_n       <= 1'b1;
            sram_we_n       <= 1'b1;
            sram_lb_n       <= 1'b1;
            sram_ub_n       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            req_ready       <= 1'b1;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            be_q            <= be_d;
            io_write_enable <= wen_d;
            {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} <= strb_d;
            rsp_valid       <= rsp_valid_d;
            req_ready       <= (state_d == StIdle);
            if (accept) begin
                sram_addr <= req_addr;
                io_write  <= req_wdata;
            end
            if (rsp_valid_d) begin
                rsp_rdata <= io_read;
            end
        end
    end

    a_no_contention: assert property (@(posedge clock) disable iff (reset)
        !(io_write_enable && !sram_oe_n));

    a_we_qualified: assert property (@(posedge clock) disable iff (reset)
        !sram_we_n |-> (io_write_enable && !sram_ce_n));

endmodule

// File: tb/tb_sram16_bus_ctrl.sv
// Self-checking bench for sram16_bus_ctrl: SRAM model, read-data scoreboard,
// table-driven back-to-back traffic and hand-timed corner cases.
module tb_sram16_bus_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [17:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic [15:0] io_write;
    logic        io_write_enable;
    logic [15:0] io_read;
    logic [17:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    always #5 clock = ~clock;

    sram16_bus_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_be          (req_be),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .io_write        (io_write),
        .io_write_enable (io_write_enable),
        .io_read         (io_read),
        .sram_addr       (sram_addr),
        .sram_ce_n       (sram_ce_n),
        .sram_oe_n       (sram_oe_n),
        .sram_we_n       (sram_we_n),
        .sram_lb_n       (sram_lb_n),
        .sram_ub_n       (sram_ub_n)
    );

    // Async SRAM model; preloaded words are restored on every reset.
    logic [15:0] mem [0:262143];

    assign io_read = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

    always @(posedge clock) begin
        if (reset) begin
            mem[18'h00010] <= 16'hA55A;
            mem[18'h00000] <= 16'h0F0F;
        end else if (!sram_ce_n && !sram_we_n && io_write_enable) begin
            if (!sram_lb_n) mem[sram_addr][7:0]  <= io_write[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] <= io_write[15:8];
        end
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          we_low_cnt = 0;
    logic [15:0] exp_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle invariants and read-data scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            if (!sram_we_n) we_low_cnt++;
            check("no_contention", 32'(io_write_enable && !sram_oe_n), 32'd0);
            check("we_qualified", 32'(!sram_we_n && !(io_write_enable && !sram_ce_n)), 32'd0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                else check("rsp_rdata", 32'(rsp_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    // Call just after a rising edge; returns just after the edge that accepted the request.
    task automatic do_req(input logic wr, input logic [17:0] a, input logic [15:0] d,
                          input logic [1:0] be, input logic [15:0] exp, output int acc_cyc);
        bit got;
        got       = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        if (!wr) exp_q.push_back(exp);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (req_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL req_ready_timeout at cycle %0d: got ready=0, expected ready=1", cyc);
        end
        acc_cyc = cyc;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int acc, prev_acc, prev_we;
        logic prev_wr;
        logic [1:0] prev_be;

        vecs[0]  = '{1'b1, 18'h00100, 16'h1111, 2'b11, 16'h0000};
        vecs[1]  = '{1'b0, 18'h00100, 16'h0000, 2'b00, 16'h1111};
        vecs[2]  = '{1'b1, 18'h00100, 16'h1234, 2'b01, 16'h0000};
        vecs[3]  = '{1'b0, 18'h00100, 16'h0000, 2'b00, 16'h1134};
        vecs[4]  = '{1'b1, 18'h00100, 16'hABCD, 2'b10, 16'h0000};
        vecs[5]  = '{1'b0, 18'h00100, 16'h0000, 2'b00, 16'hAB34};
        vecs[6]  = '{1'b1, 18'h00100, 16'hFFFF, 2'b00, 16'h0000};
        vecs[7]  = '{1'b0, 18'h00100, 16'h0000, 2'b00, 16'hAB34};
        vecs[8]  = '{1'b1, 18'h3FFFF, 16'h5A5A, 2'b11, 16'h0000};
        vecs[9]  = '{1'b0, 18'h3FFFF, 16'h0000, 2'b00, 16'h5A5A};
        vecs[10] = '{1'b0, 18'h00000, 16'h0000, 2'b00, 16'h0F0F};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}),
              32'h1f);
        check("rst_bus_en", 32'(io_write_enable), 32'd0);
        check("rst_io_write", 32'(io_write), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Write timing: WE low in cycles 2-3, bus driven 1-4, ready again in 5.
        do_req(1'b1, 18'h12345, 16'hBEEF, 2'b11, 16'h0, acc);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clock);
            check("wr_we_n", 32'(sram_we_n), 32'(!(c == 2 || c == 3)));
            check("wr_bus_en", 32'(io_write_enable), 32'(c >= 1 && c <= 4));
            check("wr_ready", 32'(req_ready), 32'(c >= 5));
            if (c <= 4) begin
                check("wr_lb_ub", 32'({sram_lb_n, sram_ub_n}), 32'd0);
                check("wr_ce_n", 32'(sram_ce_n), 32'd0);
                check("wr_data", 32'(io_write), 32'h0000BEEF);
                check("wr_addr", 32'(sram_addr), 32'h00012345);
            end
        end
        @(posedge clock);
        #1;

        // Read timing: OE low 1-2, rsp_valid only in 3, ready again in 4.
        do_req(1'b0, 18'h00010, 16'h0, 2'b00, 16'hA55A, acc);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            check("rd_oe_n", 32'(sram_oe_n), 32'(c > 2));
            check("rd_ce_n", 32'(sram_ce_n), 32'(c > 2));
            check("rd_rsp_valid", 32'(rsp_valid), 32'(c == 3));
            check("rd_ready", 32'(req_ready), 32'(c >= 4));
            if (c == 3) check("rd_rdata_hold", 32'(rsp_rdata), 32'h0000A55A);
        end
        @(posedge clock);
        #1;

        // Back-to-back traffic: accept spacing and WE pulse count per transaction.
        prev_acc = 0;
        prev_we  = 0;
        prev_wr  = 1'b0;
        prev_be  = 2'b00;
        for (int i = 0; i < 11; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp, acc);
            if (i > 0) begin
                check("b2b_gap", 32'(acc - prev_acc), prev_wr ? 32'd5 : 32'd4);
                check("we_pulse_len", 32'(we_low_cnt - prev_we),
                      (prev_wr && prev_be != 2'b00) ? 32'd2 : 32'd0);
            end
            prev_acc = acc;
            prev_we  = we_low_cnt;
            prev_wr  = vecs[i].wr;
            prev_be  = vecs[i].be;
        end
        repeat (6) @(posedge clock);
        #1;
        check("rsp_drain", 32'(exp_q.size()), 32'd0);

        // Reset during W_PULSE.
        do_req(1'b1, 18'h00200, 16'h7777, 2'b11, 16'h0, acc);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("rstw_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}),
              32'h1f);
        check("rstw_bus_en", 32'(io_write_enable), 32'd0);
        check("rstw_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        #1;

        // Reset during the last R_ACCESS cycle: the pending response must be dropped.
        do_req(1'b0, 18'h00010, 16'h0, 2'b00, 16'hA55A, acc);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clock);
        check("rstr_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}),
              32'h1f);
        check("rstr_bus_en", 32'(io_write_enable), 32'd0);
        check("rstr_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstr_ready", 32'(req_ready), 32'd1);
        repeat (3) @(posedge clock);
        #1;

        // Recovery after reset.
        do_req(1'b0, 18'h00010, 16'h0, 2'b00, 16'hA55A, acc);
        repeat (6) @(posedge clock);
        #1;
        check("rsp_drain_final", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule
